// File: rtl/aes_key_expand_inv_sbox.sv
// aes_key_expand_inv_sbox: AES-128 round-key expander (one key per clock) plus combinational inverse S-box
//   clk          rising-edge clock
//   rst          asynchronous active-high reset
//   kld, key     key load strobe and 128-bit cipher key (key[127:96] is word 0)
//   wo_0..wo_3   current round-key words, MSW first
//   round        round index of the key on wo (0..10)
//   kdone        high while the round-10 key is presented
//   inv_a/inv_d  inverse S-box lookup, purely combinational
module aes_key_expand_inv_sbox (
    input  logic         clk,
    input  logic         rst,
    input  logic         kld,
    input  logic [127:0] key,
    output logic [31:0]  wo_0,
    output logic [31:0]  wo_1,
    output logic [31:0]  wo_2,
    output logic [31:0]  wo_3,
    output logic [3:0]   round,
    output logic         kdone,
    input  logic [7:0]   inv_a,
    output logic [7:0]   inv_d
);
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            p = p ^ (b[i] ? x : 8'h00);
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // a^254 is the multiplicative inverse in GF(2^8) and maps 0 to 0 as the S-box requires
    function automatic logic [7:0] gf_inv(input logic [7:0] a);
        logic [7:0] r;
        logic [7:0] p;
        r = 8'h01;
        p = a;
        for (int i = 0; i < 8; i++) begin
            if (i != 0) r = gf_mul(r, p);
            p = gf_mul(p, p);
        end
        return r;
    endfunction

    function automatic logic [7:0] rotl(input logic [7:0] a, input int n);
        return (a << n) | (a >> (8 - n));
    endfunction

    function automatic logic [7:0] sbox(input logic [7:0] a);
        logic [7:0] b;
        b = gf_inv(a);
        return b ^ rotl(b, 1) ^ rotl(b, 2) ^ rotl(b, 3) ^ rotl(b, 4) ^ 8'h63;
    endfunction

    function automatic logic [7:0] inv_sbox(input logic [7:0] s);
        return gf_inv(rotl(s, 1) ^ rotl(s, 3) ^ rotl(s, 6) ^ 8'h05);
    endfunction

    function automatic logic [7:0] rcon(input logic [3:0] r);
        case (r)
            4'd1:    return 8'h01;
            4'd2:    return 8'h02;
            4'd3:    return 8'h04;
            4'd4:    return 8'h08;
            4'd5:    return 8'h10;
            4'd6:    return 8'h20;
            4'd7:    return 8'h40;
            4'd8:    return 8'h80;
            4'd9:    return 8'h1b;
            4'd10:   return 8'h36;
            default: return 8'h00;
        endcase
    endfunction

    logic [127:0] w_q, w_d;
    logic [3:0]   round_q, round_d;
    logic         valid_q, valid_d;
    logic [31:0]  rot, t, n0, n1, n2, n3;

    always_comb begin
        rot = {w_q[23:0], w_q[31:24]};
        t = {sbox(rot[31:24]), sbox(rot[23:16]), sbox(rot[15:8]), sbox(rot[7:0])}
            ^ {rcon(round_q + 4'd1), 24'h0};
        n0 = w_q[127:96] ^ t;
        n1 = w_q[95:64] ^ n0;
        n2 = w_q[63:32] ^ n1;
        n3 = w_q[31:0] ^ n2;
        w_d = w_q;
        round_d = round_q;
        valid_d = valid_q;
        if (kld) begin
            w_d = key;
            round_d = 4'd0;
            valid_d = 1'b1;
        end else if (valid_q && round_q < 4'd10) begin
            w_d = {n0, n1, n2, n3};
            round_d = round_q + 4'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            w_q <= '0;
            round_q <= '0;
            valid_q <= 1'b0;
        end else begin
            w_q <= w_d;
            round_q <= round_d;
            valid_q <= valid_d;
        end
    end

    assign {wo_0, wo_1, wo_2, wo_3} = w_q;
    assign round = round_q;
    assign kdone = valid_q && round_q == 4'd10;
    assign inv_d = inv_sbox(inv_a);
endmodule

// File: tb/tb_aes_key_expand_inv_sbox.sv
// tb_aes_key_expand_inv_sbox: directed checks of key expansion, restart, async reset and inverse S-box
module tb_aes_key_expand_inv_sbox;
    logic         clk, rst, kld, kdone;
    logic [127:0] key;
    logic [31:0]  wo_0, wo_1, wo_2, wo_3;
    logic [3:0]   round;
    logic [7:0]   inv_a, inv_d;
    int           n_cmp, n_bad;
    logic [7:0]   sbox [256];
    logic [7:0]   inv_ref [256];

    localparam logic [127:0] K1   = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] K1R1 = 128'ha0fafe1788542cb123a339392a6c7605;
    localparam logic [127:0] K1RA = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    localparam logic [127:0] K2   = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] K2RA = 128'h13111d7fe3944a17f307a78b4d2b30c5;

    localparam logic [2047:0] SBOX_T = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16};

    aes_key_expand_inv_sbox dut (
        .clk(clk), .rst(rst), .kld(kld), .key(key),
        .wo_0(wo_0), .wo_1(wo_1), .wo_2(wo_2), .wo_3(wo_3),
        .round(round), .kdone(kdone), .inv_a(inv_a), .inv_d(inv_d));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [127:0] wo();
        return {wo_0, wo_1, wo_2, wo_3};
    endfunction

    task automatic load(input logic [127:0] k);
        key = k;
        kld = 1'b1;
        @(negedge clk);
        kld = 1'b0;
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        for (int x = 0; x < 256; x++) begin
            sbox[x] = SBOX_T[2047 - 8 * x -: 8];
            inv_ref[SBOX_T[2047 - 8 * x -: 8]] = x[7:0];
        end
        rst = 1'b1;
        kld = 1'b0;
        key = '0;
        inv_a = 8'h00;
        repeat (2) @(negedge clk);
        chk("reset_wo", wo(), '0);
        chk("reset_round", {124'h0, round}, 128'd0);
        chk("reset_kdone", {127'h0, kdone}, 128'd0);
        rst = 1'b0;

        load(K1);
        chk("k1_r0_wo", wo(), K1);
        chk("k1_r0_round", {124'h0, round}, 128'd0);
        @(negedge clk);
        chk("k1_r1_wo", wo(), K1R1);
        chk("k1_r1_round", {124'h0, round}, 128'd1);
        chk("k1_r1_kdone", {127'h0, kdone}, 128'd0);
        repeat (8) @(negedge clk);
        chk("k1_r9_kdone", {127'h0, kdone}, 128'd0);
        @(negedge clk);
        chk("k1_r10_wo", wo(), K1RA);
        chk("k1_r10_round", {124'h0, round}, 128'd10);
        chk("k1_r10_kdone", {127'h0, kdone}, 128'd1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("k1_hold_wo", wo(), K1RA);
            chk("k1_hold_round", {124'h0, round}, 128'd10);
            chk("k1_hold_kdone", {127'h0, kdone}, 128'd1);
        end

        load(K1);
        repeat (5) @(negedge clk);
        chk("restart_at_round", {124'h0, round}, 128'd5);
        load(K2);
        chk("k2_r0_wo", wo(), K2);
        chk("k2_r0_round", {124'h0, round}, 128'd0);
        repeat (10) @(negedge clk);
        chk("k2_r10_wo", wo(), K2RA);
        chk("k2_r10_round", {124'h0, round}, 128'd10);
        chk("k2_r10_kdone", {127'h0, kdone}, 128'd1);

        load(K1);
        repeat (4) @(negedge clk);
        chk("arst_pre_round", {124'h0, round}, 128'd4);
        #2 rst = 1'b1;
        #1;
        chk("arst_wo", wo(), '0);
        chk("arst_round", {124'h0, round}, 128'd0);
        chk("arst_kdone", {127'h0, kdone}, 128'd0);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 20; i++) begin
            inv_a = 8'($urandom_range(0, 255));
            @(negedge clk);
            chk("idle_wo", wo(), '0);
            chk("idle_round", {124'h0, round}, 128'd0);
            chk("idle_kdone", {127'h0, kdone}, 128'd0);
            chk("idle_inv", {120'h0, inv_d}, {120'h0, inv_ref[inv_a]});
        end

        inv_a = 8'h63; #1 chk("inv_63", {120'h0, inv_d}, 128'h00);
        inv_a = 8'h7c; #1 chk("inv_7c", {120'h0, inv_d}, 128'h01);
        inv_a = 8'h00; #1 chk("inv_00", {120'h0, inv_d}, 128'h52);
        inv_a = 8'hed; #1 chk("inv_ed", {120'h0, inv_d}, 128'h53);
        inv_a = 8'h16; #1 chk("inv_16", {120'h0, inv_d}, 128'hff);
        for (int x = 0; x < 256; x++) begin
            inv_a = sbox[x];
            #1 chk("inv_sweep", {120'h0, inv_d}, 128'(x));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
